// File: rtl/button_debounce_pulse_pkg.sv
// Shared definitions for the button conditioning stage: FSM encoding,
// 100 MHz timing defaults and a counter-width helper.
package button_debounce_pulse_pkg;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_WAIT_PRESS   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

  localparam int DEFAULT_STABLE_COUNT  = 1000000;
  localparam int DEFAULT_REPEAT_DELAY  = 50000000;
  localparam int DEFAULT_REPEAT_PERIOD = 10000000;

  // Bits needed to hold the values 0 .. n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous level; asynchronous active-low
// reset clears both stages to 0.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/button_debounce_pulse.sv
// Synchronises and debounces a pushbutton, giving a clean level and a one-cycle
// press strobe. Define BUTTON_AUTOREPEAT_EN for auto-repeat strobes while held.
module button_debounce_pulse
  import button_debounce_pulse_pkg::*;
#(
  parameter int STABLE_COUNT  = DEFAULT_STABLE_COUNT,
  parameter int REPEAT_DELAY  = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEFAULT_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int CW = cnt_width(STABLE_COUNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);

  logic          s2;
  logic [1:0]    state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic          press_accept;
  logic          repeat_fire;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (s2)
  );

  assign press_accept = (state == ST_WAIT_PRESS) && s2 && (count == CNT_LAST);

  // The debounce counter only runs in the two WAIT states and is zeroed on
  // every state change.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    case (state)
      ST_IDLE: begin
        if (s2) begin
          state_nxt = ST_WAIT_PRESS;
          count_nxt = '0;
        end
      end
      ST_WAIT_PRESS: begin
        if (!s2) begin
          state_nxt = ST_IDLE;
          count_nxt = '0;
        end else if (count == CNT_LAST) begin
          state_nxt = ST_PRESSED;
          count_nxt = '0;
        end else begin
          count_nxt = count + CW'(1);
        end
      end
      ST_PRESSED: begin
        if (!s2) begin
          state_nxt = ST_WAIT_RELEASE;
          count_nxt = '0;
        end
      end
      ST_WAIT_RELEASE: begin
        if (s2) begin
          state_nxt = ST_PRESSED;
          count_nxt = '0;
        end else if (count == CNT_LAST) begin
          state_nxt = ST_IDLE;
          count_nxt = '0;
        end else begin
          count_nxt = count + CW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        count_nxt = '0;
      end
    endcase
  end

  // PRESSED and WAIT_RELEASE are exactly the states with bit 1 set, so the
  // registered level tracks state_nxt[1].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      btn_level <= 1'b0;
      btn_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      btn_level <= state_nxt[1];
      btn_pulse <= press_accept | repeat_fire;
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = cnt_width(REP_MAX);

  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_last;
  logic          repeating;
  logic          stay_pressed;

  // First interval is REPEAT_DELAY, every later one REPEAT_PERIOD.
  assign stay_pressed = (state == ST_PRESSED) && s2;
  assign rep_last     = repeating ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
  assign repeat_fire  = stay_pressed && (rep_cnt == rep_last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_cnt   <= '0;
      repeating <= 1'b0;
    end else if (!stay_pressed) begin
      rep_cnt   <= '0;
      repeating <= 1'b0;
    end else if (repeat_fire) begin
      rep_cnt   <= '0;
      repeating <= 1'b1;
    end else begin
      rep_cnt   <= rep_cnt + RW'(1);
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY > REPEAT_PERIOD);
  assign repeat_fire       = 1'b0;
`endif

endmodule

// File: doc/button_debounce_pulse.md
Name: button_debounce_pulse

Overview:
- Upstream conditioning stage for the up/down counter and display chain; replaces the raw pushbutton currently used as the counter's user clock.
- Synchronises a bouncing mechanical button to the board clock and debounces it.
- Emits a one-clock press pulse, so the counter runs on the single board clock with a clock enable instead of a button-derived clock.

Parameters:
- STABLE_COUNT, 1000000, consecutive clk cycles the synchronised input must hold a new level before it is accepted (10 ms at 100 MHz); must be >= 2.
- REPEAT_DELAY, 50000000, cycles held in PRESSED before the first auto-repeat pulse (used only with AUTOREPEAT_EN).
- REPEAT_PERIOD, 10000000, cycles between subsequent auto-repeat pulses (used only with AUTOREPEAT_EN).

Ports:
- clk  input  1  board clock; the only clock in the block.
- reset  input  1  asynchronous, active-low reset.
- btn_in  input  1  raw, asynchronous, bouncing pushbutton level (1 = pressed).
- btn_level  output  1  debounced registered button level.
- btn_pulse  output  1  single-clk-cycle strobe on each accepted press; drives the counter's enable.

Behaviour:
- Reset (reset = 0, asynchronous):
  - Synchroniser flops, both counters, btn_level and btn_pulse all clear to 0.
  - State goes to IDLE immediately, including mid-count.
- Synchroniser: two flops btn_in -> s1 -> s2; the FSM samples only s2.
- Debounce counter width: clog2(STABLE_COUNT); it clears on every state change.
- FSM states and transitions:
  - IDLE (btn_level = 0): s2 = 1 -> WAIT_PRESS with count = 0.
  - WAIT_PRESS: s2 = 0 -> IDLE, no output, counter cleared; s2 = 1 and count = STABLE_COUNT-1 -> PRESSED; otherwise count increments.
  - PRESSED (btn_level = 1): s2 = 0 -> WAIT_RELEASE with count = 0.
  - WAIT_RELEASE (btn_level stays 1): s2 = 1 -> PRESSED with no new pulse; s2 = 0 and count = STABLE_COUNT-1 -> IDLE; otherwise count increments.
- Outputs:
  - btn_pulse is registered and high for exactly the one cycle following the WAIT_PRESS -> PRESSED transition.
  - btn_level is registered, rises in the same cycle as btn_pulse, and falls on entry to IDLE.
- Latency:
  - btn_in first sampled high at edge 0 and held high -> btn_level = btn_pulse = 1 after edge STABLE_COUNT+2.
  - Release is symmetric: btn_level = 0 after edge STABLE_COUNT+2 from the first low sample.
- Bounce shorter than STABLE_COUNT+1 consecutive s2 samples produces no output change.
- Button held across reset release: the block starts in IDLE, follows the normal press path and emits one btn_pulse.
- At most one btn_pulse per accepted press; btn_pulse never asserts in back-to-back cycles.

Optional Feature:
- Macro: BUTTON_AUTOREPEAT_EN.
- When defined:
  - A repeat counter runs while in PRESSED.
  - First extra btn_pulse fires REPEAT_DELAY cycles after PRESSED entry; further pulses fire every REPEAT_PERIOD cycles.
  - The repeat counter clears on leaving PRESSED.
  - Returning to PRESSED from WAIT_RELEASE restarts the full REPEAT_DELAY.
- When undefined: no repeat counter is synthesised; exactly one pulse per press.

Decomposition:
- Shared package holds:
  - the 2-bit FSM state encoding (IDLE = 0, WAIT_PRESS = 1, PRESSED = 2, WAIT_RELEASE = 3);
  - default STABLE_COUNT, REPEAT_DELAY and REPEAT_PERIOD constants for 100 MHz.
- One sub-module: sync_2ff (two-flop synchroniser with asynchronous active-low reset to 0); reused for other switch inputs.

Test Plan (simulation uses STABLE_COUNT = 4, REPEAT_DELAY = 10, REPEAT_PERIOD = 3):
- Clean press: btn_in 0 -> 1 sampled at edge 0, held -> btn_pulse high only in the cycle after edge 6; btn_level = 1 from edge 6 onward.
- Bounce: btn_in toggles 1,0,1,0 on successive edges, then settles at 1 -> exactly one btn_pulse, asserted 6 edges after the final rising sample.
- Glitch: btn_in high for 3 cycles, then low -> btn_pulse and btn_level stay 0 throughout.
- Release bounce: after a press, btn_in low for 2 cycles, high again, then low and held -> no extra pulse; btn_level falls 6 edges after the final low sample.
- Reset mid-operation: reset = 0 while in WAIT_PRESS with count = 2 -> outputs 0 asynchronously; btn_in held high through reset release -> one btn_pulse after STABLE_COUNT+2 edges.
- BUTTON_AUTOREPEAT_EN defined, btn_in held 30 cycles after PRESSED entry -> pulses at PRESSED+0, +10, +13, +16, ...; with the macro undefined -> a single pulse only.
